// File: rtl/gat_feat_readout.sv
// Feature readout for the GAT accelerator: drains the final-layer feature
// BRAM after inference, streams the words out on valid/ready with node and
// frame boundary flags, and reports a per-node argmax class label.
module gat_feat_readout #(
   parameter int NUM_NODES     = 2708,
   parameter int FEAT_PER_NODE = 7,
   parameter int FEAT_WIDTH    = 32,
   parameter int RD_LAT        = 2,
   parameter int FEAT_DEPTH    = NUM_NODES * FEAT_PER_NODE,
   parameter int FEAT_ADDR_W   = $clog2(FEAT_DEPTH),
   parameter int LBL_W         = $clog2(FEAT_PER_NODE),
   parameter int NODE_W        = $clog2(NUM_NODES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   gat_ready,
   output logic [FEAT_ADDR_W+1:0] feat_bram_addrb,
   input  logic [FEAT_WIDTH-1:0]  feat_bram_dout,
   output logic [FEAT_WIDTH-1:0]  m_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   m_tlast,
   output logic                   m_tuser,
   output logic                   lbl_valid,
   output logic [LBL_W-1:0]       lbl_class,
   output logic [NODE_W-1:0]      lbl_node,
   output logic                   busy,
   output logic                   done
);

   localparam int FIFO_DEPTH = RD_LAT + 2;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam int SUM_W      = $clog2(2 * FIFO_DEPTH + 1);
   localparam logic [FEAT_ADDR_W-1:0] ADDR_PRE_LAST = FEAT_ADDR_W'(FEAT_DEPTH - 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    gat_prev_q;
   logic [FEAT_ADDR_W-1:0]  addr_q;
   logic                    iss_q;              // an address is on the BRAM port this cycle
   logic [RD_LAT-1:0]       vld_q;              // vld_q[RD_LAT-1] marks dout valid this cycle
   logic [FEAT_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [LBL_W-1:0]        f_q;
   logic [NODE_W-1:0]       n_q;
   logic [FEAT_WIDTH-1:0]   best_q;
   logic [LBL_W-1:0]        idx_q;
   logic                    lbl_valid_q;
   logic [LBL_W-1:0]        lbl_class_q;
   logic [NODE_W-1:0]       lbl_node_q;
   logic                    busy_q, done_q;

   logic                    issue_s, first_s, rise_s, push_s, pop_s;
   logic                    last_s, user_s, credit_ok_s;
   logic [SUM_W-1:0]        sum_s;
   logic [FEAT_WIDTH-1:0]   best_new_s;
   logic [LBL_W-1:0]        idx_new_s;

   // Circular pointer advance for a FIFO whose depth need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH - 1)) begin
         return PTR_W'(0);
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   assign rise_s   = gat_ready & ~gat_prev_q;
   assign push_s   = vld_q[RD_LAT-1];
   assign m_tvalid = (cnt_q != CNT_W'(0));
   assign pop_s    = m_tvalid & m_tready;
   assign m_tdata  = fifo_mem_q[rd_ptr_q];
   assign last_s   = (f_q == LBL_W'(FEAT_PER_NODE - 1));
   assign user_s   = last_s & (n_q == NODE_W'(NUM_NODES - 1));
   assign m_tlast  = m_tvalid & last_s;
   assign m_tuser  = m_tvalid & user_s;

   assign feat_bram_addrb = {addr_q, 2'b00};
   assign lbl_valid       = lbl_valid_q;
   assign lbl_class       = lbl_class_q;
   assign lbl_node        = lbl_node_q;
   assign busy            = busy_q;
   assign done            = done_q;

   // Credit: FIFO words left after this cycle's pop plus every read still in the pipe.
   always_comb begin
      sum_s = SUM_W'(cnt_q) + SUM_W'(iss_q);
      for (int i = 0; i < RD_LAT; i++) begin
         sum_s = sum_s + SUM_W'(vld_q[i]);
      end
      sum_s       = sum_s - SUM_W'(pop_s);
      credit_ok_s = (sum_s < SUM_W'(FIFO_DEPTH));
   end

   // Next state and read-issue decision.
   always_comb begin
      state_d = state_q;
      issue_s = 1'b0;
      first_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rise_s) begin
               state_d = S_RUN;
               issue_s = 1'b1;
               first_s = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (credit_ok_s) begin
               issue_s = 1'b1;
               if (addr_q == ADDR_PRE_LAST) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            if (pop_s && user_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE: begin
            if (!gat_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Running argmax including the word handshaking this cycle; ties keep the lower index.
   always_comb begin
      best_new_s = best_q;
      idx_new_s  = idx_q;
      if (f_q == LBL_W'(0)) begin
         best_new_s = m_tdata;
         idx_new_s  = LBL_W'(0);
      end else if ($signed(m_tdata) > $signed(best_q)) begin
         best_new_s = m_tdata;
         idx_new_s  = f_q;
      end else begin
         best_new_s = best_q;
         idx_new_s  = idx_q;
      end
   end

   // FSM, status flags and gat_ready edge history; history resets high so a
   // level already asserted when reset releases is not taken as a new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         gat_prev_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gat_prev_q <= gat_ready;
         busy_q     <= (state_d == S_RUN) || (state_d == S_DRAIN);
         done_q     <= (state_d == S_DONE);
      end
   end

   // Read address and the in-flight marker pipeline aligned to BRAM latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= FEAT_ADDR_W'(0);
         iss_q  <= 1'b0;
         vld_q  <= RD_LAT'(0);
      end else begin
         if (issue_s) begin
            addr_q <= first_s ? FEAT_ADDR_W'(0) : addr_q + FEAT_ADDR_W'(1);
         end
         iss_q    <= issue_s;
         vld_q[0] <= iss_q;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
         end
      end
   end

   // Output FIFO: capture returning BRAM data, release on stream handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= FEAT_WIDTH'(0);
         end
         wr_ptr_q <= PTR_W'(0);
         rd_ptr_q <= PTR_W'(0);
         cnt_q    <= CNT_W'(0);
      end else begin
         if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= feat_bram_dout;
            wr_ptr_q             <= ptr_inc(wr_ptr_q);
         end
         if (pop_s) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Output-side feature/node counters, argmax state and label pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q         <= LBL_W'(0);
         n_q         <= NODE_W'(0);
         best_q      <= FEAT_WIDTH'(0);
         idx_q       <= LBL_W'(0);
         lbl_valid_q <= 1'b0;
         lbl_class_q <= LBL_W'(0);
         lbl_node_q  <= NODE_W'(0);
      end else begin
         lbl_valid_q <= pop_s & last_s;
         if (pop_s) begin
            best_q <= best_new_s;
            idx_q  <= idx_new_s;
            if (last_s) begin
               f_q         <= LBL_W'(0);
               n_q         <= user_s ? NODE_W'(0) : n_q + NODE_W'(1);
               lbl_class_q <= idx_new_s;
               lbl_node_q  <= n_q;
            end else begin
               f_q <= f_q + LBL_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_gat_feat_readout.sv
// Directed bench for gat_feat_readout: 3 nodes x 4 features, RD_LAT 2,
// plus RD_LAT 1 and 4 instances for latency and throughput.
module tb_gat_feat_readout;

   localparam int NN = 3, FPN = 4, FW = 32, DEPTH = 12, AW = 4, LW = 2, NW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic gat_ready, m_tready, gr1, gr4;
   logic one;
   logic [AW+1:0] addrb, addrb_1, addrb_4;
   logic [FW-1:0] dout, dout_1, dout_4, tdata, tdata_1, tdata_4;
   logic tvalid, tlast, tuser, lbl_valid, busy, done;
   logic tvalid_1, tlast_1, tuser_1, lblv_1, busy_1, done_1;
   logic tvalid_4, tlast_4, tuser_4, lblv_4, busy_4, done_4;
   logic [LW-1:0] lbl_class, lcls_1, lcls_4;
   logic [NW-1:0] lbl_node, lnode_1, lnode_4;

   logic [FW-1:0] bram_mem [DEPTH];
   logic [AW-1:0] p2 [2];
   logic [AW-1:0] p1 [1];
   logic [AW-1:0] p4 [4];

   int tests = 0, fails = 0, cyc = 0;
   logic [FW-1:0] q_data [$];
   bit            q_last [$];
   bit            q_user [$];
   int            q_cyc  [$];
   logic [LW-1:0] q_cls  [$];
   logic [NW-1:0] q_node [$];
   logic [AW+1:0] q_addr [$];
   int busy_cyc = -1, done_cyc = -1, stall_err = 0;
   bit prev_stall = 1'b0;
   logic [FW-1:0] prev_data = '0;
   int b1 = -1, v1 = -1, l1 = -1, c1 = 0, e1 = 0;
   int b4 = -1, v4 = -1, l4 = -1, c4 = 0, e4 = 0;

   assign one = 1'b1;

   gat_feat_readout #(.NUM_NODES(NN), .FEAT_PER_NODE(FPN), .FEAT_WIDTH(FW), .RD_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .gat_ready(gat_ready), .feat_bram_addrb(addrb),
      .feat_bram_dout(dout), .m_tdata(tdata), .m_tvalid(tvalid), .m_tready(m_tready),
      .m_tlast(tlast), .m_tuser(tuser), .lbl_valid(lbl_valid), .lbl_class(lbl_class),
      .lbl_node(lbl_node), .busy(busy), .done(done));

   gat_feat_readout #(.NUM_NODES(NN), .FEAT_PER_NODE(FPN), .FEAT_WIDTH(FW), .RD_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .gat_ready(gr1), .feat_bram_addrb(addrb_1),
      .feat_bram_dout(dout_1), .m_tdata(tdata_1), .m_tvalid(tvalid_1), .m_tready(one),
      .m_tlast(tlast_1), .m_tuser(tuser_1), .lbl_valid(lblv_1), .lbl_class(lcls_1),
      .lbl_node(lnode_1), .busy(busy_1), .done(done_1));

   gat_feat_readout #(.NUM_NODES(NN), .FEAT_PER_NODE(FPN), .FEAT_WIDTH(FW), .RD_LAT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .gat_ready(gr4), .feat_bram_addrb(addrb_4),
      .feat_bram_dout(dout_4), .m_tdata(tdata_4), .m_tvalid(tvalid_4), .m_tready(one),
      .m_tlast(tlast_4), .m_tuser(tuser_4), .lbl_valid(lblv_4), .lbl_class(lcls_4),
      .lbl_node(lnode_4), .busy(busy_4), .done(done_4));

   // BRAM models: address pipelines of depth 2, 1 and 4.
   always @(posedge clk) begin
      p2[0] <= addrb[AW+1:2];
      p2[1] <= p2[0];
      p1[0] <= addrb_1[AW+1:2];
      p4[0] <= addrb_4[AW+1:2];
      for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
   end
   assign dout   = bram_mem[p2[1]];
   assign dout_1 = bram_mem[p1[0]];
   assign dout_4 = bram_mem[p4[3]];

   // Monitor on the falling edge: handshakes, labels, addresses, stalls.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            if (busy && busy_cyc < 0) busy_cyc = cyc;
            if (done && done_cyc < 0) done_cyc = cyc;
            if (busy && (q_addr.size() == 0 || addrb != q_addr[$])) q_addr.push_back(addrb);
            if (prev_stall && (!tvalid || tdata !== prev_data)) stall_err++;
            prev_stall = tvalid && !m_tready;
            prev_data  = tdata;
            if (tvalid && m_tready) begin
               q_data.push_back(tdata);
               q_last.push_back(tlast);
               q_user.push_back(tuser);
               q_cyc.push_back(cyc);
            end
            if (lbl_valid) begin
               q_cls.push_back(lbl_class);
               q_node.push_back(lbl_node);
            end
            if (busy_1 && b1 < 0) b1 = cyc;
            if (tvalid_1) begin
               if (v1 < 0) v1 = cyc;
               l1 = cyc;
               if (tdata_1 !== 32'(c1 + 1)) e1++;
               c1++;
            end
            if (busy_4 && b4 < 0) b4 = cyc;
            if (tvalid_4) begin
               if (v4 < 0) v4 = cyc;
               l4 = cyc;
               if (tdata_4 !== 32'(c4 + 1)) e4++;
               c4++;
            end
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon;
      q_data.delete(); q_last.delete(); q_user.delete(); q_cyc.delete();
      q_cls.delete(); q_node.delete(); q_addr.delete();
      busy_cyc = -1; done_cyc = -1; stall_err = 0;
   endtask

   task automatic fill_ramp;
      for (int k = 0; k < DEPTH; k++) bram_mem[k] = 32'(k + 1);
   endtask

   // Starts a frame with a fresh gat_ready rise and waits for done (bounded).
   task automatic run_frame(input bit bp);
      gat_ready = 1'b0;
      m_tready  = 1'b1;
      tick;
      tick;
      clear_mon;
      gat_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         m_tready = bp ? (((i % 4) == 0 || (i % 4) == 3) ? 1'b1 : 1'b0) : 1'b1;
         tick;
         if (done_cyc >= 0) break;
      end
      m_tready = 1'b1;
      tests++;
      if (done_cyc < 0) begin
         fails++;
         $display("FAIL frame_timeout: done never rose within 400 cycles");
      end
   endtask

   task automatic test_reset;
      logic [47:0] outs;
      repeat (3) tick;
      outs = {addrb, tdata, tvalid, tlast, tuser, lbl_valid, lbl_class, lbl_node, busy, done};
      tests++;
      if (outs !== 48'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
      rst_n = 1'b1;
      tick;
      outs = {addrb, tdata, tvalid, tlast, tuser, lbl_valid, lbl_class, lbl_node, busy, done};
      tests++;
      if (outs !== 48'd0) begin fails++; $display("FAIL post_reset_idle: got %h want 0", outs); end
   endtask

   task automatic test_stream;
      run_frame(1'b0);
      tests++;
      if (q_data.size() != DEPTH) begin
         fails++; $display("FAIL stream_count: got %0d want %0d", q_data.size(), DEPTH);
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            tests++;
            if (q_data[k] !== 32'(k + 1) || q_last[k] !== ((k % FPN) == FPN - 1) || q_user[k] !== (k == DEPTH - 1)) begin
               fails++;
               $display("FAIL stream_word%0d: got data %0d last %0d user %0d want %0d %0d %0d",
                        k, q_data[k], q_last[k], q_user[k], k + 1, (k % FPN) == FPN - 1, k == DEPTH - 1);
            end
         end
         tests++;
         if (q_cyc[0] - busy_cyc != 3) begin
            fails++; $display("FAIL stream_first_latency: got %0d want 3", q_cyc[0] - busy_cyc);
         end
         tests++;
         if (q_cyc[DEPTH-1] - q_cyc[0] != DEPTH - 1) begin
            fails++; $display("FAIL stream_throughput: got span %0d want %0d", q_cyc[DEPTH-1] - q_cyc[0], DEPTH - 1);
         end
         tests++;
         if (done_cyc != q_cyc[DEPTH-1] + 1) begin
            fails++; $display("FAIL stream_done_timing: got cycle %0d want %0d", done_cyc, q_cyc[DEPTH-1] + 1);
         end
      end
      tests++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         fails++; $display("FAIL stream_status: got busy %0b done %0b want 0 1", busy, done);
      end
      tests++;
      if (q_cls.size() != NN) begin
         fails++; $display("FAIL stream_label_count: got %0d want %0d", q_cls.size(), NN);
      end else begin
         for (int n = 0; n < NN; n++) begin
            tests++;
            if (q_cls[n] !== 2'd3 || q_node[n] !== 2'(n)) begin
               fails++; $display("FAIL stream_label%0d: got class %0d node %0d want 3 %0d", n, q_cls[n], q_node[n], n);
            end
         end
      end
      tests++;
      if (q_addr.size() != DEPTH) begin
         fails++; $display("FAIL stream_addr_count: got %0d want %0d", q_addr.size(), DEPTH);
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            tests++;
            if (q_addr[k] !== 6'(4 * k)) begin
               fails++; $display("FAIL stream_addr%0d: got %h want %h", k, q_addr[k], 4 * k);
            end
         end
      end
   endtask

   task automatic test_done_hold;
      int hold_err = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (done !== 1'b1 || busy !== 1'b0 || addrb !== 6'h2C || tvalid !== 1'b0) hold_err++;
      end
      tests++;
      if (hold_err != 0) begin fails++; $display("FAIL done_hold: got %0d bad cycles want 0", hold_err); end
      gat_ready = 1'b0;
      tests++;
      if (done !== 1'b1) begin fails++; $display("FAIL done_before_fall: got %0b want 1", done); end
      tick;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL done_clear: got done %0b busy %0b want 0 0", done, busy);
      end
   endtask

   task automatic test_backpressure;
      run_frame(1'b1);
      tests++;
      if (q_data.size() != DEPTH) begin
         fails++; $display("FAIL bp_count: got %0d want %0d", q_data.size(), DEPTH);
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            tests++;
            if (q_data[k] !== 32'(k + 1) || q_user[k] !== (k == DEPTH - 1)) begin
               fails++; $display("FAIL bp_word%0d: got %0d user %0d want %0d", k, q_data[k], q_user[k], k + 1);
            end
         end
      end
      tests++;
      if (stall_err != 0) begin fails++; $display("FAIL bp_stall_hold: got %0d unstable stalls want 0", stall_err); end
      tests++;
      if (q_cls.size() != NN) begin fails++; $display("FAIL bp_label_count: got %0d want %0d", q_cls.size(), NN); end
   endtask

   task automatic test_argmax;
      logic [LW-1:0] want [3];
      bram_mem[0]  = -32'sd5;        bram_mem[1]  = 32'sd7;   bram_mem[2]  = 32'sd7;   bram_mem[3]  = -32'sd100;
      bram_mem[4]  = 32'h8000_0000;  bram_mem[5]  = -32'sd1;  bram_mem[6]  = -32'sd2;  bram_mem[7]  = -32'sd3;
      bram_mem[8]  = 32'sd3;         bram_mem[9]  = -32'sd7;  bram_mem[10] = 32'sd9;   bram_mem[11] = 32'sd9;
      want[0] = 2'd1; want[1] = 2'd1; want[2] = 2'd2;
      run_frame(1'b0);
      tests++;
      if (q_cls.size() != NN) begin
         fails++; $display("FAIL argmax_count: got %0d want %0d", q_cls.size(), NN);
      end else begin
         for (int n = 0; n < NN; n++) begin
            tests++;
            if (q_cls[n] !== want[n] || q_node[n] !== 2'(n)) begin
               fails++; $display("FAIL argmax_node%0d: got class %0d node %0d want %0d %0d", n, q_cls[n], q_node[n], want[n], n);
            end
         end
      end
      fill_ramp;
   endtask

   task automatic test_abort;
      logic [47:0] outs;
      gat_ready = 1'b0;
      tick;
      tick;
      clear_mon;
      gat_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick;
         if (q_data.size() >= 6) break;
      end
      tests++;
      if (q_data.size() != 6) begin fails++; $display("FAIL abort_reach6: got %0d want 6", q_data.size()); end
      rst_n = 1'b0;
      #1;
      outs = {addrb, tdata, tvalid, tlast, tuser, lbl_valid, lbl_class, lbl_node, busy, done};
      tests++;
      if (outs !== 48'd0) begin fails++; $display("FAIL abort_outputs: got %h want 0", outs); end
      tick;
      rst_n = 1'b1;
      clear_mon;
      repeat (20) tick;
      tests++;
      if (busy_cyc >= 0 || q_data.size() != 0 || addrb !== 6'h00) begin
         fails++; $display("FAIL abort_no_restart: got busy_seen %0d words %0d addr %h want -1 0 00",
                           busy_cyc, q_data.size(), addrb);
      end
      run_frame(1'b0);
      tests++;
      if (q_data.size() != DEPTH || q_addr.size() == 0) begin
         fails++; $display("FAIL abort_restart_count: got %0d want %0d", q_data.size(), DEPTH);
      end else begin
         tests++;
         if (q_addr[0] !== 6'h00) begin fails++; $display("FAIL abort_restart_addr: got %h want 00", q_addr[0]); end
         for (int k = 0; k < DEPTH; k++) begin
            tests++;
            if (q_data[k] !== 32'(k + 1)) begin
               fails++; $display("FAIL abort_restart_word%0d: got %0d want %0d", k, q_data[k], k + 1);
            end
         end
      end
   endtask

   task automatic test_latency;
      gr1 = 1'b0; gr4 = 1'b0;
      tick;
      tick;
      b1 = -1; v1 = -1; l1 = -1; c1 = 0; e1 = 0;
      b4 = -1; v4 = -1; l4 = -1; c4 = 0; e4 = 0;
      gr1 = 1'b1; gr4 = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick;
         if (done_1 && done_4) break;
      end
      tests++;
      if (c1 != DEPTH || e1 != 0) begin fails++; $display("FAIL lat1_data: got %0d words %0d bad want 12 0", c1, e1); end
      tests++;
      if (v1 - b1 != 2) begin fails++; $display("FAIL lat1_first: got %0d want 2", v1 - b1); end
      tests++;
      if (l1 - v1 != DEPTH - 1) begin fails++; $display("FAIL lat1_span: got %0d want %0d", l1 - v1, DEPTH - 1); end
      tests++;
      if (c4 != DEPTH || e4 != 0) begin fails++; $display("FAIL lat4_data: got %0d words %0d bad want 12 0", c4, e4); end
      tests++;
      if (v4 - b4 != 5) begin fails++; $display("FAIL lat4_first: got %0d want 5", v4 - b4); end
      tests++;
      if (l4 - v4 != DEPTH - 1) begin fails++; $display("FAIL lat4_span: got %0d want %0d", l4 - v4, DEPTH - 1); end
   endtask

   initial begin
      rst_n     = 1'b0;
      gat_ready = 1'b0;
      m_tready  = 1'b0;
      gr1       = 1'b0;
      gr4       = 1'b0;
      fill_ramp;
      test_reset;
      test_stream;
      test_done_hold;
      test_backpressure;
      test_argmax;
      test_abort;
      test_latency;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
